// File: rtl/lcd_timing_pkg.sv
// Shared LCD panel timing defaults (800x480 @ 1056x525 pixel clocks)
package lcd_timing_pkg;

   typedef logic [10:0] lcd_cnt_t;

   localparam lcd_cnt_t LCD_H_SYNC  = 11'd128;
   localparam lcd_cnt_t LCD_H_BACK  = 11'd88;
   localparam lcd_cnt_t LCD_H_DISP  = 11'd800;
   localparam lcd_cnt_t LCD_H_TOTAL = 11'd1056;

   localparam lcd_cnt_t LCD_V_SYNC  = 11'd2;
   localparam lcd_cnt_t LCD_V_BACK  = 11'd33;
   localparam lcd_cnt_t LCD_V_DISP  = 11'd480;
   localparam lcd_cnt_t LCD_V_TOTAL = 11'd525;

   // First active column/row: sync width plus back porch
   localparam lcd_cnt_t LCD_H_DE_START = LCD_H_SYNC + LCD_H_BACK;   // 216
   localparam lcd_cnt_t LCD_V_DE_START = LCD_V_SYNC + LCD_V_BACK;   // 35

   // True when pos lies in [start, start+len)
   function automatic logic in_window(input lcd_cnt_t pos,
                                      input lcd_cnt_t start,
                                      input lcd_cnt_t len);
      lcd_cnt_t stop;
      stop = start + len;
      return (pos >= start) && (pos < stop);
   endfunction

endpackage

// File: rtl/lcd_timing_driver.sv
// LCD timing generator: h/v counters, sync/DE decode, pixel request
// addressing one cycle ahead of DE, and panel control pins.
module lcd_timing_driver
   import lcd_timing_pkg::*;
#(
   parameter lcd_cnt_t H_SYNC  = LCD_H_SYNC,
   parameter lcd_cnt_t H_BACK  = LCD_H_BACK,
   parameter lcd_cnt_t H_DISP  = LCD_H_DISP,
   parameter lcd_cnt_t H_TOTAL = LCD_H_TOTAL,
   parameter lcd_cnt_t V_SYNC  = LCD_V_SYNC,
   parameter lcd_cnt_t V_BACK  = LCD_V_BACK,
   parameter lcd_cnt_t V_DISP  = LCD_V_DISP,
   parameter lcd_cnt_t V_TOTAL = LCD_V_TOTAL
)(
   input  logic        lcd_clk,
   input  logic        sys_rst_n,
   input  logic [15:0] pixel_data,
   output logic [10:0] pixel_xpos,
   output logic [10:0] pixel_ypos,
   output logic        lcd_hs,
   output logic        lcd_vs,
   output logic        lcd_de,
   output logic [15:0] lcd_rgb,
   output logic        lcd_bl,
   output logic        lcd_rst,
   output logic        lcd_pclk,
   output logic        frame_start
);

   localparam lcd_cnt_t H_DE_START = H_SYNC + H_BACK;
   localparam lcd_cnt_t V_DE_START = V_SYNC + V_BACK;
   localparam lcd_cnt_t H_REQ_START = H_DE_START - 11'd1;

   lcd_cnt_t h_cnt;
   lcd_cnt_t v_cnt;
   logic     h_last;
   logic     v_last;
   logic     v_active;
   logic     data_req;

   assign h_last = (h_cnt == H_TOTAL - 11'd1);
   assign v_last = (v_cnt == V_TOTAL - 11'd1);

   // Pixel/line counters; line counter advances only when the pixel counter wraps
   always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= v_last ? '0 : v_cnt + 11'd1;
      end else begin
         h_cnt <= h_cnt + 11'd1;
      end
   end

   // Backlight turns on at the first clock after reset release
   always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) lcd_bl <= 1'b0;
      else            lcd_bl <= 1'b1;
   end

   // Sync, DE and request-address decode from the registered counters.
   // Requests lead DE by one column so the generator's registered pixel
   // lands exactly on the DE cycle.
   always_comb begin
      lcd_hs      = (h_cnt >= H_SYNC);
      lcd_vs      = (v_cnt >= V_SYNC);
      v_active    = in_window(v_cnt, V_DE_START, V_DISP);
      lcd_de      = in_window(h_cnt, H_DE_START, H_DISP) && v_active;
      data_req    = in_window(h_cnt, H_REQ_START, H_DISP) && v_active;
      pixel_xpos  = data_req ? h_cnt - H_REQ_START : '0;
      pixel_ypos  = data_req ? v_cnt - V_DE_START  : '0;
      lcd_rgb     = lcd_de ? pixel_data : '0;
      frame_start = (h_cnt == '0) && (v_cnt == '0);
   end

   assign lcd_pclk = lcd_clk;
   assign lcd_rst  = sys_rst_n;

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Scoreboarded bench for lcd_timing_driver using a reduced timing set.
module tb_lcd_timing_driver;

   localparam int HS  = 4;
   localparam int HB  = 3;
   localparam int HD  = 10;
   localparam int HT  = 20;
   localparam int VS  = 2;
   localparam int VB  = 2;
   localparam int VD  = 5;
   localparam int VT  = 12;
   localparam int HDS = HS + HB;
   localparam int VDS = VS + VB;
   localparam int FRAME = HT * VT;
   localparam int NCYC  = 2600;

   logic        lcd_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [15:0] pixel_data = '0;
   logic [10:0] pixel_xpos, pixel_ypos;
   logic        lcd_hs, lcd_vs, lcd_de, lcd_bl, lcd_rst, lcd_pclk, frame_start;
   logic [15:0] lcd_rgb;

   lcd_timing_driver #(
      .H_SYNC (11'(HS)), .H_BACK (11'(HB)), .H_DISP (11'(HD)), .H_TOTAL(11'(HT)),
      .V_SYNC (11'(VS)), .V_BACK (11'(VB)), .V_DISP (11'(VD)), .V_TOTAL(11'(VT))
   ) dut (
      .lcd_clk    (lcd_clk),
      .sys_rst_n  (sys_rst_n),
      .pixel_data (pixel_data),
      .pixel_xpos (pixel_xpos),
      .pixel_ypos (pixel_ypos),
      .lcd_hs     (lcd_hs),
      .lcd_vs     (lcd_vs),
      .lcd_de     (lcd_de),
      .lcd_rgb    (lcd_rgb),
      .lcd_bl     (lcd_bl),
      .lcd_rst    (lcd_rst),
      .lcd_pclk   (lcd_pclk),
      .frame_start(frame_start)
   );

   always #5 lcd_clk = ~lcd_clk;

   typedef struct {
      logic        hs, vs, de, fs, bl, rst;
      logic [10:0] x, y;
      logic [15:0] rgb;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] tbl [HD*VD];
   int          checks = 0;
   int          errors = 0;
   logic        started = 1'b0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Pixel generator image: one random colour per visible pixel
   function automatic logic [15:0] pix(input logic [10:0] x, input logic [10:0] y);
      if (int'(x) < HD && int'(y) < VD) return tbl[int'(y) * HD + int'(x)];
      return 16'hDEAD;
   endfunction

   // Reference: panel state t clocks after reset release, from the timing rules
   function automatic exp_t model(input int t, input logic bl);
      exp_t e;
      int h, v;
      logic hwin, hreq, vwin;
      h = t % HT;
      v = (t / HT) % VT;
      hwin = (h >= HDS) && (h < HDS + HD);
      hreq = (h + 1 >= HDS) && (h + 1 < HDS + HD);
      vwin = (v >= VDS) && (v < VDS + VD);
      e.hs  = (h >= HS);
      e.vs  = (v >= VS);
      e.de  = hwin && vwin;
      e.x   = (hreq && vwin) ? 11'(h + 1 - HDS) : '0;
      e.y   = (hreq && vwin) ? 11'(v - VDS) : '0;
      e.rgb = e.de ? tbl[(v - VDS) * HD + (h - HDS)] : '0;
      e.fs  = (h == 0) && (v == 0);
      e.bl  = bl;
      e.rst = 1'b1;
      return e;
   endfunction

   // Driver: reset schedule, registered pixel generator, expectation push
   initial begin
      int   r1, r2, d2, t;
      logic rst_now, rst_prev;
      logic [10:0] px, py;
      exp_t e;
      foreach (tbl[i]) tbl[i] = 16'($urandom);
      r1 = 700 + $urandom_range(0, 200);
      r2 = 1500 + $urandom_range(0, 200);
      d2 = $urandom_range(1, 5);
      px = '0; py = '0; t = 0; rst_prev = 1'b0;
      for (int c = 0; c < NCYC; c++) begin
         @(posedge lcd_clk);
         #1;
         pixel_data = pix(px, py);
         rst_now = !((c < 3) || (c >= r1 && c < r1 + 3) || (c >= r2 && c < r2 + d2));
         sys_rst_n = rst_now;
         if (!rst_now) begin
            e = '{hs:1'b0, vs:1'b0, de:1'b0, fs:1'b1, bl:1'b0, rst:1'b0,
                  x:'0, y:'0, rgb:'0};
         end else if (!rst_prev) begin
            t = 0;
            e = model(t, 1'b0);
         end else begin
            t++;
            e = model(t, 1'b1);
         end
         rst_prev = rst_now;
         sb.push_back(e);
         started = 1'b1;
         @(negedge lcd_clk);
         px = pixel_xpos;
         py = pixel_ypos;
      end
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Monitor: compare every cycle, plus frame period and DE run length
   int   fs_gap = 0;
   logic fs_valid = 1'b0;
   logic fs_prev = 1'b0;
   int   de_run = 0;

   always @(negedge lcd_clk) begin
      exp_t e;
      if (started) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: queue empty, expected an entry");
         end else begin
            e = sb.pop_front();
            chk("hs",   16'(lcd_hs),      16'(e.hs));
            chk("vs",   16'(lcd_vs),      16'(e.vs));
            chk("de",   16'(lcd_de),      16'(e.de));
            chk("xpos", 16'(pixel_xpos),  16'(e.x));
            chk("ypos", 16'(pixel_ypos),  16'(e.y));
            chk("rgb",  lcd_rgb,          e.rgb);
            chk("frame_start", 16'(frame_start), 16'(e.fs));
            chk("bl",   16'(lcd_bl),      16'(e.bl));
            chk("rst",  16'(lcd_rst),     16'(e.rst));
            chk("pclk", 16'(lcd_pclk),    16'h0);
         end
         if (!sys_rst_n) begin
            fs_valid = 1'b0;
            fs_prev  = 1'b0;
            fs_gap   = 0;
            de_run   = 0;
         end else begin
            fs_gap++;
            if (frame_start && !fs_prev) begin
               if (fs_valid) chk("frame_period", 16'(fs_gap), 16'(FRAME));
               fs_gap   = 0;
               fs_valid = 1'b1;
            end
            fs_prev = frame_start;
            if (lcd_de) de_run++;
            else if (de_run != 0) begin
               chk("de_run", 16'(de_run), 16'(HD));
               de_run = 0;
            end
         end
      end
   end

endmodule

// File: doc/lcd_timing_driver.md
LCD_TIMING_DRIVER -- requirements
Module: lcd_timing_driver

Interface
REQ-001 SHALL have parameter H_SYNC, 11'd128, horizontal sync width in pclk.
REQ-002 SHALL have parameter H_BACK, 11'd88, horizontal back porch.
REQ-003 SHALL have parameter H_DISP, 11'd800, active pixels per line.
REQ-004 SHALL have parameter H_TOTAL, 11'd1056, line period (sync+back+disp+front 40).
REQ-005 SHALL have parameter V_SYNC, 11'd2, vertical sync width in lines.
REQ-006 SHALL have parameter V_BACK, 11'd33, vertical back porch.
REQ-007 SHALL have parameter V_DISP, 11'd480, active lines per frame.
REQ-008 SHALL have parameter V_TOTAL, 11'd525, frame period in lines (front 10).
REQ-009 SHALL have port lcd_clk  input  1  pixel clock; all state on rising edge.
REQ-010 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-011 SHALL have port pixel_data  input  16  RGB565 from the pixel generator, valid one cycle after the matching pixel_xpos/pixel_ypos.
REQ-012 SHALL have port pixel_xpos  output  11  requested column, 0..H_DISP-1.
REQ-013 SHALL have port pixel_ypos  output  11  requested row, 0..V_DISP-1.
REQ-014 SHALL have port lcd_hs / lcd_vs  output  1 each  active-low syncs.
REQ-015 SHALL have port lcd_de  output  1  data enable.
REQ-016 SHALL have port lcd_rgb  output  16  panel pixel bus.
REQ-017 SHALL have port lcd_bl / lcd_rst / lcd_pclk  output  1 each  backlight, panel reset, panel clock.
REQ-018 SHALL have port frame_start  output  1  one-cycle pulse at frame origin.

Function
REQ-019 h_cnt SHALL count 0..H_TOTAL-1 each cycle and wrap to 0.
REQ-020 v_cnt SHALL increment only on the cycle h_cnt wraps; it SHALL wrap to 0 after V_TOTAL-1.
REQ-021 lcd_hs SHALL be 0 when h_cnt < H_SYNC, else 1; lcd_vs SHALL be 0 when v_cnt < V_SYNC, else 1.
REQ-022 lcd_de SHALL be 1 when H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_DISP and V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+V_DISP.
REQ-023 Internal data_req SHALL equal lcd_de's window shifted one cycle earlier in h (h_cnt from H_SYNC+H_BACK-1 to H_SYNC+H_BACK+H_DISP-2), same v window.
REQ-024 pixel_xpos SHALL be h_cnt-(H_SYNC+H_BACK-1) when data_req, else 0.
REQ-025 pixel_ypos SHALL be v_cnt-(V_SYNC+V_BACK) when data_req, else 0.
REQ-026 This 1-cycle lead SHALL compensate the pixel generator's registered 1-cycle latency, so pixel_data aligns with lcd_de.
REQ-027 lcd_rgb SHALL equal pixel_data when lcd_de=1, else 16'h0000.
REQ-028 frame_start SHALL be 1 for exactly the cycle h_cnt=0 and v_cnt=0.
REQ-029 lcd_pclk SHALL equal lcd_clk; lcd_rst SHALL equal sys_rst_n.
REQ-030 lcd_bl SHALL be a register: 0 in reset, 1 from first clock after release.
REQ-031 hs/vs/de/xpos/ypos/rgb/frame_start SHALL be combinational decodes of the registered counters; all arithmetic 11-bit unsigned, no overflow possible within parameter ranges.

Reset
REQ-032 While sys_rst_n=0: h_cnt=0, v_cnt=0, lcd_bl=0, hence lcd_hs=0, lcd_vs=0, lcd_de=0, lcd_rgb=0, pixel_xpos=0, pixel_ypos=0, frame_start=1.
REQ-033 Reset asserted mid-frame SHALL immediately (asynchronously) return counters to 0; the first cycle after release SHALL be h_cnt=0, v_cnt=0, restarting a full frame.

Structure
REQ-034 Timing defaults (H_*/V_* values, derived H_DE_START=216, V_DE_START=35) SHALL live in shared package lcd_timing_pkg for reuse by other LCD stages.
REQ-035 Single module, no sub-module; counters and decodes in one file.

Verification
REQ-036 Release reset -> lcd_hs low for cycles 0..127, high 128..1055; next hs fall at cycle 1056.
REQ-037 Run one frame -> lcd_vs low for 2*1056=2112 cycles; frame_start pulses period 554400 cycles.
REQ-038 Line v_cnt=35 -> pixel_xpos=0 at h_cnt=215, =799 at h_cnt=1014; lcd_de high h_cnt 216..1015 exactly (800 cycles); pixel_ypos=0.
REQ-039 Drive pixel_data = {5'b0,pixel_xpos_d1} via 1-cycle register model -> lcd_rgb equals column index 0..799 on every de cycle, 0 otherwise.
REQ-040 Assert sys_rst_n low at v_cnt=200,h_cnt=500 for 3 cycles -> outputs at reset values; after release frame restarts, next frame_start 554400 cycles after release.
